rhdb: RTL
=========

# rhdb

RH11 data buffer (RHDB) with its silo. It is a first-word-fall-through FIFO between the Unibus/DMA side and the Massbus drive side. It produces the `rhBUFIR`, `rhBUFOR` and `rhSETDLT` inputs consumed by the RHCS2 register, and it supplies the RHDB read value to the RH11 register mux.

## Interface

Parameters:
- `DEPTH`, default 64: silo depth in 16-bit words; must be a power of two, minimum 4.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `devRESET`  in  1  device reset from UBA; synchronous clear.
- `devLOBYTE`  in  1  Unibus low-byte select.
- `devHIBYTE`  in  1  Unibus high-byte select.
- `rhDATAI`  in  36  Unibus data in; bits [15:0] used.
- `rhdbWRITE`  in  1  programmed write to RHDB; pushes one word.
- `rhdbREAD`  in  1  programmed read of RHDB; pops one word.
- `rhCLR`  in  1  controller clear; flushes the silo.
- `mbWRSTB`  in  1  Massbus write strobe: drive delivers a word (read operation).
- `mbRDSTB`  in  1  Massbus read strobe: drive takes a word (write operation).
- `mbDATAI`  in  16  Massbus data from drive.
- `mbDATAO`  out  16  head word to drive.
- `rhDB`  out  16  head word to register mux.
- `rhBUFIR`  out  1  input ready: silo not full.
- `rhBUFOR`  out  1  output ready: silo not empty.
- `rhSETDLT`  out  1  one-cycle device-late pulse.

## Operation

- Clear (`rst | devRESET | rhCLR`):
  - Read/write pointers and count go to 0 and the `rhSETDLT` register goes to 0.
  - Storage contents are not cleared.
  - Clear overrides every push and pop in the same cycle.
- Push sources, at most one push per cycle:
  - `mbWRSTB` pushes `mbDATAI`.
  - Otherwise `rhdbWRITE` pushes `{devHIBYTE ? rhDATAI[15:8] : 8'o0, devLOBYTE ? rhDATAI[7:0] : 8'o0}`.
  - If both assert together, `mbWRSTB` wins and the programmed write is discarded.
- Pop sources, at most one pop per cycle:
  - `mbRDSTB` pops.
  - Otherwise `rhdbREAD` pops.
  - If both assert together, one word is removed.
- Simultaneous push and pop: both are performed and the count is unchanged.
  - When empty, push-with-pop is treated as push only; the pop is an underrun (rules below).
  - When full, push-with-pop is legal; the pop frees a slot the same cycle.
- Full, when the push is not accompanied by a pop:
  - `mbWRSTB` is an overrun: data dropped, `rhSETDLT` pulses.
  - `rhdbWRITE` is dropped silently.
- Empty:
  - `mbRDSTB` is an underrun: no pop, `rhSETDLT` pulses.
  - `rhdbREAD` is ignored; `rhDB` reads 0.
- Outputs:
  - `rhDB = mbDATAO` = word at the read pointer when count ≠ 0, else 16'o0.
  - `rhBUFIR = (count != DEPTH)`.
  - `rhBUFOR = (count != 0)`.
- Arithmetic and widths:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits, range 0..DEPTH.

## Timing

- Reset values: `rhBUFIR`=1, `rhBUFOR`=0, `rhDB`=`mbDATAO`=0, `rhSETDLT`=0.
- Push at edge N; `rhBUFOR` and the valid head word appear after edge N (cycle N+1). Latency is 1 clock.
- Pop at edge N; the next word is on `rhDB` in cycle N+1.
- `rhSETDLT` is registered: high for exactly one cycle, the cycle after the offending strobe.
  - Repeated offending strobes give repeated pulses.
- `rhBUFIR` and `rhBUFOR` are combinational from the registered count, so they are glitch-free per cycle.
- Clear mid-transfer: the silo is empty from the next cycle. A strobe in the clear cycle produces no DLT.

## Structure

- `rhdb.vh` holds `rhDB_*` field macros and the default depth constant; it is shared with the register-mux and DMA blocks.
- Sub-module `RHFIFO` is a generic synchronous FWFT FIFO (parameters `WIDTH`, `DEPTH`) that provides push, pop, count, full and empty.
- `rhdb` wraps `RHFIFO` and adds the source arbitration, byte merge and DLT logic.

## Test plan

- Reset, then push 3 words via `mbWRSTB` (0o1, 0o2, 0o3) → `rhBUFOR`=1 from cycle 2; 3 `rhdbREAD` pops return 0o1, 0o2, 0o3; then `rhBUFOR`=0 and `rhDB`=0.
- Fill 64 words → `rhBUFIR`=0; a 65th `mbWRSTB` → `rhSETDLT` is a one-cycle pulse, count stays 64, the 65th word is lost.
- Empty silo, `mbRDSTB` → `rhSETDLT` one-cycle pulse, count 0; `rhdbREAD` on empty → no pulse, `rhDB`=0.
- Full silo, `mbWRSTB`+`mbRDSTB` same cycle → no DLT, count 64, head advances, new word lands at the tail.
- Byte write `rhdbWRITE` with only `devHIBYTE`, data 0o177777 → the pushed word is 0o177400. `rhdbWRITE` coincident with `mbWRSTB` → only the Massbus word is stored.
- 20 words loaded, then `rhCLR` coincident with `mbRDSTB` → next cycle count 0, `rhBUFIR`=1, no `rhSETDLT`; wrap test: 200 push/pop pairs preserve order.

Source files
------------

// File: rtl/rhdb_pkg.sv
// rhdb_pkg: shared silo depth, push-source encoding and Unibus byte-merge helper
package rhdb_pkg;
  localparam int RHDB_DEPTH = 64;
  typedef enum logic [1:0] {SRC_NONE, SRC_MB, SRC_UB} src_t;
  function automatic logic [15:0] rhdb_merge(input logic hi, input logic lo, input logic [15:0] d);
    return {hi ? d[15:8] : 8'o0, lo ? d[7:0] : 8'o0};
  endfunction
endpackage

// File: rtl/rhdb_fifo.sv
// rhdb_fifo: generic synchronous first-word-fall-through FIFO with count, full and empty
module rhdb_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;
  assign o_count = r_count;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];
  // storage is never cleared; only the pointers define what is valid
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_data;
  // pointer and occupancy update; clear beats any push or pop in the same cycle
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/rhdb.sv
// rhdb: RH11 data buffer silo with Unibus/Massbus arbitration and device-late detection
module rhdb
  import rhdb_pkg::*;
#(
  parameter int DEPTH = RHDB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devRESET,
  input  logic        devLOBYTE,
  input  logic        devHIBYTE,
  input  logic [35:0] rhDATAI,
  input  logic        rhdbWRITE,
  input  logic        rhdbREAD,
  input  logic        rhCLR,
  input  logic        mbWRSTB,
  input  logic        mbRDSTB,
  input  logic [15:0] mbDATAI,
  output logic [15:0] mbDATAO,
  output logic [15:0] rhDB,
  output logic        rhBUFIR,
  output logic        rhBUFOR,
  output logic        rhSETDLT
);
  localparam int CW = $clog2(DEPTH) + 1;
  src_t          w_src;
  logic          w_clr, w_push, w_pop, w_full, w_empty, w_ovr, w_unr, w_unused;
  logic [15:0]   w_din, w_head;
  logic [CW-1:0] w_count;
  logic          r_dlt;
  assign w_clr    = rst | devRESET | rhCLR;
  assign w_pop    = mbRDSTB | rhdbREAD;
  assign w_ovr    = mbWRSTB & w_full & ~w_pop;
  assign w_unr    = mbRDSTB & w_empty;
  assign w_unused = &{1'b0, rhDATAI[35:16], w_count};
  // Massbus strobe owns the push slot; a coincident programmed write is discarded
  always_comb begin
    w_src  = mbWRSTB ? SRC_MB : rhdbWRITE ? SRC_UB : SRC_NONE;
    w_push = w_src != SRC_NONE;
    w_din  = w_src == SRC_MB ? mbDATAI : rhdb_merge(devHIBYTE, devLOBYTE, rhDATAI[15:0]);
  end
  rhdb_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_din),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // device-late pulses for one cycle after a Massbus overrun or underrun
  always_ff @(posedge clk)
    r_dlt <= w_clr ? 1'b0 : (w_ovr | w_unr);
  assign mbDATAO  = w_head;
  assign rhDB     = w_head;
  assign rhBUFIR  = ~w_full;
  assign rhBUFOR  = ~w_empty;
  assign rhSETDLT = r_dlt;
endmodule
